// File: rtl/and_operation.sv
// Bitwise AND leaf unit: combinational a & b, a registered result with
// zero/all-ones/popcount flags, and a running AND mask over valid pairs.
module and_operation #(
  parameter  int N  = 8,
  localparam int PW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic          in_valid,
  input  logic          acc_clr,
  output logic [N-1:0]  result,
  output logic          out_valid,
  output logic [N-1:0]  result_q,
  output logic          zero_q,
  output logic          ones_q,
  output logic [PW-1:0] popcount_q,
  output logic [N-1:0]  acc_q
);

  logic [N-1:0]  res_d;
  logic          zero_d;
  logic          ones_d;
  logic [PW-1:0] pc_d;
  logic [N-1:0]  acc_d;

  function automatic logic [PW-1:0] popcount_f(input logic [N-1:0] v);
    logic [PW-1:0] cnt;
    cnt = {PW{1'b0}};
    for (int i = 0; i < N; i++) begin
      cnt = cnt + PW'(v[i]);
    end
    return cnt;
  endfunction

  assign result = res_d;

  // Next-state for the flagged result and the mask; clear-and-load wins over plain clear.
  always_comb begin
    res_d  = a & b;
    zero_d = (res_d == {N{1'b0}});
    ones_d = (res_d == {N{1'b1}});
    pc_d   = popcount_f(res_d);
    if (acc_clr && in_valid) begin
      acc_d = res_d;
    end else if (acc_clr) begin
      acc_d = {N{1'b1}};
    end else if (in_valid) begin
      acc_d = acc_q & res_d;
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      result_q   <= {N{1'b0}};
      zero_q     <= 1'b0;
      ones_q     <= 1'b0;
      popcount_q <= {PW{1'b0}};
      acc_q      <= {N{1'b1}};
    end else begin
      out_valid <= in_valid;
      acc_q     <= acc_d;
      if (in_valid) begin
        result_q   <= res_d;
        zero_q     <= zero_d;
        ones_q     <= ones_d;
        popcount_q <= pc_d;
      end
    end
  end

endmodule

// File: tb/tb_and_operation.sv
// Directed vector table plus randomized run against a behavioural model,
// with a second N=1 instance exercising the single-bit boundary.
module tb_and_operation;

  logic       clk;
  logic       rst;
  logic [7:0] a, b;
  logic       in_valid, acc_clr;
  logic [7:0] result, result_q, acc_q;
  logic       out_valid, zero_q, ones_q;
  logic [3:0] popcount_q;

  logic       result1, result_q1, acc_q1, out_valid1, zero_q1, ones_q1;
  logic [0:0] popcount_q1;

  int n_cmp = 0;
  int n_bad = 0;

  and_operation #(.N(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .acc_clr(acc_clr),
    .result(result), .out_valid(out_valid), .result_q(result_q), .zero_q(zero_q),
    .ones_q(ones_q), .popcount_q(popcount_q), .acc_q(acc_q)
  );

  and_operation #(.N(1)) dut1 (
    .clk(clk), .rst(rst), .a(a[0]), .b(b[0]), .in_valid(in_valid), .acc_clr(acc_clr),
    .result(result1), .out_valid(out_valid1), .result_q(result_q1), .zero_q(zero_q1),
    .ones_q(ones_q1), .popcount_q(popcount_q1), .acc_q(acc_q1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [7:0] ta, input logic [7:0] tb_, input logic tv,
                      input logic tclr, input logic tr);
    @(negedge clk);
    a = ta; b = tb_; in_valid = tv; acc_clr = tclr; rst = tr;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       v, clr, r;
    logic [7:0] e_res, e_rq;
    logic       e_ov, e_z, e_o;
    logic [3:0] e_pc;
    logic [7:0] e_acc;
  } vec_t;

  vec_t tbl[16];

  // behavioural model state
  logic [7:0] m_rq, m_acc;
  logic       m_ov, m_z, m_o;
  int         m_pc;
  logic       m_z1, m_o1;

  initial begin
    tbl[0]  = '{8'h96, 8'hAA, 1'b0, 1'b0, 1'b1, 8'h82, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'hFF};
    tbl[1]  = '{8'h96, 8'hAA, 1'b1, 1'b0, 1'b0, 8'h82, 8'h82, 1'b1, 1'b0, 1'b0, 4'd2, 8'h82};
    tbl[2]  = '{8'h96, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h82, 8'h82, 1'b0, 1'b0, 1'b0, 4'd2, 8'h82};
    tbl[3]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 4'd8, 8'h82};
    tbl[4]  = '{8'hF0, 8'h0F, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0, 8'h00};
    tbl[5]  = '{8'hF0, 8'h0F, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'hFF};
    tbl[6]  = '{8'hF7, 8'hFF, 1'b1, 1'b0, 1'b0, 8'hF7, 8'hF7, 1'b1, 1'b0, 1'b0, 4'd7, 8'hF7};
    tbl[7]  = '{8'hFF, 8'h7F, 1'b1, 1'b0, 1'b0, 8'h7F, 8'h7F, 1'b1, 1'b0, 1'b0, 4'd7, 8'h77};
    tbl[8]  = '{8'hFE, 8'hFF, 1'b1, 1'b0, 1'b0, 8'hFE, 8'hFE, 1'b1, 1'b0, 1'b0, 4'd7, 8'h76};
    tbl[9]  = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFE, 1'b0, 1'b0, 1'b0, 4'd7, 8'hFF};
    tbl[10] = '{8'h3C, 8'h0F, 1'b1, 1'b1, 1'b0, 8'h0C, 8'h0C, 1'b1, 1'b0, 1'b0, 4'd2, 8'h0C};
    tbl[11] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'hFF};
    tbl[12] = '{8'h55, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h55, 8'h55, 1'b1, 1'b0, 1'b0, 4'd4, 8'h55};
    for (int i = 13; i < 16; i++)
      tbl[i] = '{8'hAA, 8'h0F, 1'b0, 1'b0, 1'b0, 8'h0A, 8'h55, 1'b0, 1'b0, 1'b0, 4'd4, 8'h55};

    rst = 1'b1; in_valid = 1'b0; acc_clr = 1'b0;
    a = 8'b10010110; b = 8'b10101010;
    #20;
    check("comb_result", {24'd0, result}, 32'h82);

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].a, tbl[i].b, tbl[i].v, tbl[i].clr, tbl[i].r);
      check($sformatf("t%0d.result", i),     {24'd0, result},     {24'd0, tbl[i].e_res});
      check($sformatf("t%0d.result_q", i),   {24'd0, result_q},   {24'd0, tbl[i].e_rq});
      check($sformatf("t%0d.out_valid", i),  {31'd0, out_valid},  {31'd0, tbl[i].e_ov});
      check($sformatf("t%0d.zero_q", i),     {31'd0, zero_q},     {31'd0, tbl[i].e_z});
      check($sformatf("t%0d.ones_q", i),     {31'd0, ones_q},     {31'd0, tbl[i].e_o});
      check($sformatf("t%0d.popcount_q", i), {28'd0, popcount_q}, {28'd0, tbl[i].e_pc});
      check($sformatf("t%0d.acc_q", i),      {24'd0, acc_q},      {24'd0, tbl[i].e_acc});
    end

    // randomized run; the model starts from a reset cycle
    for (int k = 0; k < 400; k++) begin
      logic [7:0] ra, rb, x;
      logic       rv, rc, rr;
      ra = 8'($urandom);
      rb = 8'($urandom) | (($urandom_range(0, 3) == 0) ? 8'hFF : 8'h00);
      rv = ($urandom_range(0, 3) != 0);
      rc = ($urandom_range(0, 7) == 0);
      rr = (k == 0) || ($urandom_range(0, 49) == 0);
      step(ra, rb, rv, rc, rr);
      x = ra & rb;
      if (rr) begin
        m_ov = 1'b0; m_rq = 8'h00; m_z = 1'b0; m_o = 1'b0; m_pc = 0; m_acc = 8'hFF;
        m_z1 = 1'b0; m_o1 = 1'b0;
      end else begin
        m_ov = rv;
        if (rv) begin
          m_rq = x; m_z = (x == 8'h00); m_o = (x == 8'hFF); m_pc = $countones(x);
          m_z1 = ~x[0]; m_o1 = x[0];
        end
        if (rc && rv) m_acc = x;
        else if (rc) m_acc = 8'hFF;
        else if (rv) m_acc = m_acc & x;
      end
      check("r.result",     {24'd0, result},     {24'd0, x});
      check("r.result_q",   {24'd0, result_q},   {24'd0, m_rq});
      check("r.out_valid",  {31'd0, out_valid},  {31'd0, m_ov});
      check("r.zero_q",     {31'd0, zero_q},     {31'd0, m_z});
      check("r.ones_q",     {31'd0, ones_q},     {31'd0, m_o});
      check("r.popcount_q", {28'd0, popcount_q}, 32'(m_pc));
      check("r.acc_q",      {24'd0, acc_q},      {24'd0, m_acc});
      check("n1.result",    {31'd0, result1},    {31'd0, x[0]});
      check("n1.result_q",  {31'd0, result_q1},  {31'd0, m_rq[0]});
      check("n1.out_valid", {31'd0, out_valid1}, {31'd0, m_ov});
      check("n1.zero_q",    {31'd0, zero_q1},    {31'd0, m_z1});
      check("n1.ones_q",    {31'd0, ones_q1},    {31'd0, m_o1});
      check("n1.popcount",  {31'd0, popcount_q1},{31'd0, (m_o1 ? 1'b1 : 1'b0)});
      check("n1.acc_q",     {31'd0, acc_q1},     {31'd0, m_acc[0]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/and_operation.md
# and_operation

Parameterised bitwise-AND unit with a combinational result path and a registered, flagged result path. It produces `a & b` immediately and, on a valid strobe, captures the result together with zero, all-ones and population-count flags one cycle later. An accumulating AND mask over successive valid operand pairs is also maintained. It sits in the datapath as a leaf logic unit feeding status and masking logic.

## Interface
- `N`, default 8, operand and result width in bits (N ≥ 1).
- `PW`, derived as $clog2(N+1) (4 for N=8); width of the popcount output. Not overridable.

- `clk`  in  1  single rising-edge clock.
- `rst`  in  1  reset; synchronous and active-high.
- `a`  in  N  operand A.
- `b`  in  N  operand B.
- `in_valid`  in  1  operand pair is valid this cycle.
- `acc_clr`  in  1  clear the accumulated mask.
- `result`  out  N  combinational `a & b`.
- `out_valid`  out  1  registered outputs updated in the previous cycle.
- `result_q`  out  N  registered `a & b`.
- `zero_q`  out  1  registered result equals 0.
- `ones_q`  out  1  registered result equals all ones.
- `popcount_q`  out  PW  number of set bits in the registered result.
- `acc_q`  out  N  running AND of all valid results since the last clear.

## Operation
- `result` = `a & b`, bit by bit, purely combinational. It does not depend on `clk`, `rst` or `in_valid`. It is valid at all times, including during reset.
- When `in_valid` = 1 at a rising edge:
  - `result_q` <= `a & b`.
  - `zero_q` <= (`a & b` == 0).
  - `ones_q` <= (`a & b` == all ones).
  - `popcount_q` <= number of ones in `a & b`, in the range 0..N.
- When `in_valid` = 0, `result_q`, `zero_q`, `ones_q` and `popcount_q` hold their values.
- `out_valid` <= `in_valid` every cycle, so it is a one-cycle pulse per accepted pair.
- Accumulator update, with priority from highest to lowest:
  1. `acc_clr` = 1 and `in_valid` = 1: `acc_q` <= `a & b` (clear and load in the same cycle).
  2. `acc_clr` = 1 only: `acc_q` <= all ones.
  3. `in_valid` = 1 only: `acc_q` <= `acc_q & a & b`.
  4. Otherwise `acc_q` holds.
- No backpressure; every valid pair is accepted.
- All operations are unsigned and bitwise; there is no carry and no overflow.

## Timing
- Combinational path: zero latency.
- Registered path: one cycle of latency. Operands sampled at edge k appear on `result_q`, the flags and `acc_q` after edge k, with `out_valid` = 1 during cycle k+1.
- Reset is synchronous and takes priority over every other input. At the reset edge:
  - `out_valid` = 0
  - `result_q` = 0
  - `zero_q` = 0
  - `ones_q` = 0
  - `popcount_q` = 0
  - `acc_q` = all ones
- Reset asserted mid-stream discards any pair presented in that cycle. `out_valid` is 0 in the following cycle.
- Back-to-back `in_valid` gives one result per cycle, and `out_valid` stays high continuously.
- N = 1 boundary: `zero_q` and `ones_q` are complementary after any valid cycle. `popcount_q` is 1 bit wide.

## Test plan
- **Combinational result:** N=8, `a`=8'b10010110, `b`=8'b10101010 held, no clock → after 20 time units `result` = 8'h82.
- **Registered path and flags:** same operands with `in_valid` pulsed for one edge → next cycle:
  - `result_q` = 8'h82
  - `popcount_q` = 2
  - `zero_q` = 0, `ones_q` = 0
  - `out_valid` = 1 for exactly one cycle.
- **Flag extremes:**
  - `a`=8'hFF, `b`=8'hFF, valid → `ones_q`=1, `popcount_q`=8, `zero_q`=0.
  - Then `a`=8'hF0, `b`=8'h0F, valid → `zero_q`=1, `popcount_q`=0, `ones_q`=0.
- **Accumulator sequence:**
  - Reset → `acc_q`=8'hFF.
  - Valid pairs (8'hF7,8'hFF), then (8'hFF,8'h7F), then (8'hFE,8'hFF) → `acc_q` = 8'hF7, then 8'h77, then 8'h76.
  - `acc_clr` alone → 8'hFF.
  - `acc_clr` with valid (8'h3C,8'h0F) → 8'h0C.
- **Reset mid-stream:** `in_valid`=1 with `rst`=1 on the same edge → all registered outputs at reset values and `out_valid`=0 next cycle. `result` still equals `a & b` throughout.
- **Hold behaviour:** after a valid pair, drive new operands with `in_valid`=0 for 3 cycles → `result` tracks the new operands immediately; `result_q`, the flags and `acc_q` stay unchanged; `out_valid`=0.
